demux_dispatch_ctrl: RTL and testbench

- Sequences the 8-line 8-bit demultiplexer: buffers (data, destination) write requests from the bus master in a small FIFO.
- Drives the demux select/input lines plus a one-hot load strobe so each word lands in exactly one of 8 destination registers.
- Holds a word back while its destination is not ready; flags prolonged blocking.

---
 rtl/demux_dispatch_ctrl.sv | 97 +++++++++
 tb/tb_demux_dispatch_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch controller for the 8-line 8-bit demultiplexer: buffers (dest, data)
// requests in a FIFO and steers each word to exactly one destination register.
module demux_dispatch_ctrl #(
  parameter int DEPTH       = 4,
  parameter int STALL_LIMIT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic [2:0]             in_dest,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             dest_ready,
  output logic [7:0]             demux_in,
  output logic [2:0]             demux_sel,
  output logic [7:0]             load,
  output logic [$clog2(DEPTH):0] count,
  output logic                   idle,
  output logic                   stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    LIMIT    = 8'(STALL_LIMIT);

  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    stall_cnt;
  logic [7:0]    stall_cnt_next;
  logic [10:0]   head;
  logic [2:0]    head_dest;
  logic [7:0]    head_data;
  logic          empty;
  logic          push;
  logic          pop;

  assign head      = mem[rd_ptr];
  assign head_dest = head[10:8];
  assign head_data = head[7:0];
  assign empty     = (count == '0);
  assign in_ready  = !rst && (count != FULL_CNT);
  assign push      = in_valid && in_ready;
  // Head-of-line: only the oldest entry's destination is ever consulted.
  assign pop       = !empty && dest_ready[head_dest];
  assign idle      = empty && (load == 8'h00);

  always_comb begin
    stall_cnt_next = stall_cnt;
    if (pop || empty) begin
      stall_cnt_next = 8'h00;
    end else if (stall_cnt != LIMIT) begin
      stall_cnt_next = stall_cnt + 8'h01;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_dest, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      load      <= 8'h00;
      demux_sel <= 3'd0;
      demux_in  <= 8'h00;
      stall_cnt <= 8'h00;
      stall     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        demux_sel <= head_dest;
        demux_in  <= head_data;
        load      <= 8'h01 << head_dest;
      end else begin
        load <= 8'h00;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      stall_cnt <= stall_cnt_next;
      stall     <= (stall_cnt_next == LIMIT);
    end
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux_dispatch_ctrl;

  localparam int DEPTH = 4;
  localparam int LIMIT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dest_ready;
  logic [7:0] demux_in;
  logic [2:0] demux_sel;
  logic [7:0] load;
  logic [2:0] count;
  logic       idle;
  logic       stall;

  int checks   = 0;
  int failures = 0;

  demux_dispatch_ctrl #(.DEPTH(DEPTH), .STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest),
    .in_valid(in_valid), .in_ready(in_ready), .dest_ready(dest_ready),
    .demux_in(demux_in), .demux_sel(demux_sel), .load(load),
    .count(count), .idle(idle), .stall(stall)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {dest, data}, outputs as they must be after the edge.
  logic [10:0] q[$];
  logic [7:0]  m_load = 8'h00;
  logic [2:0]  m_sel  = 3'd0;
  logic [7:0]  m_in   = 8'h00;
  int          m_blk  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic was_empty;
    logic do_pop;
    logic do_push;
    if (rst) begin
      q.delete();
      m_load = 8'h00; m_sel = 3'd0; m_in = 8'h00; m_blk = 0;
      return;
    end
    was_empty = (q.size() == 0);
    do_push   = in_valid && (q.size() != DEPTH);
    do_pop    = !was_empty && dest_ready[q[0][10:8]];
    if (do_pop) begin
      m_sel  = q[0][10:8];
      m_in   = q[0][7:0];
      m_load = 8'h01 << q[0][10:8];
      void'(q.pop_front());
    end else begin
      m_load = 8'h00;
    end
    if (do_pop || was_empty) m_blk = 0;
    else if (m_blk < LIMIT) m_blk++;
    if (do_push) q.push_back({in_dest, in_data});
  endtask

  task automatic compare();
    chk("in_ready",  int'(in_ready),  int'(!rst && q.size() != DEPTH));
    chk("load",      int'(load),      int'(m_load));
    chk("demux_sel", int'(demux_sel), int'(m_sel));
    chk("demux_in",  int'(demux_in),  int'(m_in));
    chk("count",     int'(count),     q.size());
    chk("idle",      int'(idle),      int'(q.size() == 0 && m_load == 8'h00));
    chk("stall",     int'(stall),     int'(m_blk == LIMIT));
  endtask

  // Inputs are set before calling; model advances, edge happens, compare at negedge.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic push_word(input logic [2:0] d, input logic [7:0] v);
    in_valid = 1'b1; in_dest = d; in_data = v;
    cyc();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_dest = 3'd1; dest_ready = 8'hFF;
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_load",     int'(load),     0);
    chk("rst_sel",      int'(demux_sel), 0);
    chk("rst_in",       int'(demux_in), 0);
    chk("rst_count",    int'(count),    0);
    chk("rst_idle",     int'(idle),     1);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rel_in_ready", int'(in_ready), 1);

    // Single dispatch
    dest_ready = 8'hFF;
    push_word(3'd3, 8'd7);
    in_valid = 1'b0;
    cyc();
    chk("single_load", int'(load), 8'h08);
    chk("single_sel",  int'(demux_sel), 3);
    chk("single_in",   int'(demux_in), 7);
    cyc();
    chk("single_load0", int'(load), 0);
    chk("single_idle",  int'(idle), 1);

    // Sweep all destinations back to back
    for (int d = 0; d < 8; d++) begin
      push_word(3'(d), 8'd7);
      if (d > 0) chk("sweep_load", int'(load), 1 << (d - 1));
      chk("sweep_count_le2", int'(count <= 2), 1);
    end
    in_valid = 1'b0;
    cyc();
    chk("sweep_last", int'(load), 8'h80);
    chk("sweep_in", int'(demux_in), 7);

    // Full and backpressure
    dest_ready = 8'h00;
    for (int i = 0; i < 5; i++) push_word(3'(i), 8'(8'h10 + i));
    in_valid = 1'b0;
    chk("full_count",    int'(count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    dest_ready = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("drain_load", int'(load), 1 << i);
      chk("drain_data", int'(demux_in), 8'h10 + i);
    end
    chk("drain_in_ready", int'(in_ready), 1);

    // Head-of-line blocking and stall
    dest_ready = 8'b0010_0000;
    push_word(3'd2, 8'hA2);
    push_word(3'd5, 8'hA5);
    in_valid = 1'b0;
    for (int i = 0; i < 13; i++) begin
      cyc();
      chk("hol_noload", int'(load), 0);
    end
    chk("hol_nostall", int'(stall), 0);
    cyc();
    chk("hol_stall", int'(stall), 1);
    dest_ready = 8'b0010_0100;
    cyc();
    chk("hol_load2", int'(load), 8'h04);
    chk("hol_stall_clr", int'(stall), 0);
    cyc();
    chk("hol_load5", int'(load), 8'h20);

    // Reset mid-operation
    dest_ready = 8'h00;
    for (int i = 0; i < 3; i++) push_word(3'(i), 8'(8'h30 + i));
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_load",  int'(load), 0);
    chk("mid_rst_stall", int'(stall), 0);
    dest_ready = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mid_rst_noload", int'(load), 0);
    end

    // Randomized traffic with varying destination availability
    for (int blk = 0; blk < 40; blk++) begin
      int mode;
      mode = blk % 4;
      for (int c = 0; c < 80; c++) begin
        rst      = ($urandom_range(0, 299) == 0);
        in_valid = ($urandom_range(0, 3) != 0);
        in_dest  = 3'($urandom_range(0, 7));
        in_data  = 8'($urandom);
        case (mode)
          0:       dest_ready = 8'hFF;
          1:       dest_ready = 8'($urandom);
          2:       dest_ready = 8'($urandom) & 8'($urandom) & 8'($urandom);
          default: dest_ready = (c % 20 < 17) ? 8'h00 : 8'hFF;
        endcase
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
